// File: rtl/psr_pkg.sv
// psr_pkg: shared types and constants for the processor status register unit.
//   Flag bit positions inside the status byte, flag-operation and branch
//   condition encodings, handshake FSM states and the reset status value.
package psr_pkg;
    localparam int N_BIT = 7;
    localparam int V_BIT = 6;
    localparam int D_BIT = 3;
    localparam int I_BIT = 2;
    localparam int Z_BIT = 1;
    localparam int C_BIT = 0;
    // Bits 5 and 4 have no storage meaning; they always read back as 1.
    localparam logic [7:0] PSR_FIXED = 8'h30;
    localparam logic [7:0] RESET_PSR = 8'h34;
    typedef enum logic [3:0] {
        OP_NOP = 4'd0,
        OP_CLC = 4'd1,
        OP_SEC = 4'd2,
        OP_CLI = 4'd3,
        OP_SEI = 4'd4,
        OP_CLD = 4'd5,
        OP_SED = 4'd6,
        OP_CLV = 4'd7,
        OP_PLP = 4'd8,
        OP_INT = 4'd9
    } flag_op_t;
    typedef enum logic [2:0] {
        BPL = 3'd0,
        BMI = 3'd1,
        BVC = 3'd2,
        BVS = 3'd3,
        BCC = 3'd4,
        BCS = 3'd5,
        BNE = 3'd6,
        BEQ = 3'd7
    } cond_sel_t;
    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ACK      = 2'd1,
        ST_WAIT_LOW = 2'd2
    } psr_state_t;
endpackage

// File: rtl/psr_unit_branch_cond.sv
// branch_cond: 6502 branch condition evaluation from the N, V, Z, C flags.
//   n_i/v_i/z_i/c_i : current registered flags
//   cond_sel_i      : branch select (BPL..BEQ)
//   taken_o         : condition result
module branch_cond
    import psr_pkg::*;
(
    input  logic      n_i,
    input  logic      v_i,
    input  logic      z_i,
    input  logic      c_i,
    input  cond_sel_t cond_sel_i,
    output logic      taken_o
);
    logic flag;
    // Upper two select bits pick the flag, the low bit picks set/clear polarity.
    always_comb begin
        flag    = cond_sel_i[2] ? (cond_sel_i[1] ? z_i : c_i) : (cond_sel_i[1] ? v_i : n_i);
        taken_o = cond_sel_i[0] ? flag : !flag;
    end
endmodule

// File: rtl/psr_unit.sv
// psr_unit: processor status register with ALU flag-update handshake responder.
//   mem_clk/resb            : clock, asynchronous active-low reset
//   psr_update_request      : ALU capture request, held until acknowledged
//   n/v/z/c_result          : ALU flags, valid while the request is high
//   ack_update_request      : one-cycle acknowledge of a capture
//   flag_op/flag_op_valid   : flag instruction strobe (CLC..CLV, PLP, INT)
//   db_in/db_out            : pulled byte for PLP, pushed byte for PHP/BRK/IRQ
//   brk_push                : B bit value presented on db_out
//   psr_to_id               : status byte {N,V,1,1,D,I,Z,C}
//   cond_sel/branch_taken   : branch condition select and result
module psr_unit #(
    parameter logic [7:0] RESET_PSR = psr_pkg::RESET_PSR
) (
    input  logic       mem_clk,
    input  logic       resb,
    input  logic       psr_update_request,
    input  logic       n_result,
    input  logic       v_result,
    input  logic       z_result,
    input  logic       c_result,
    output logic       ack_update_request,
    input  logic [3:0] flag_op,
    input  logic       flag_op_valid,
    input  logic [7:0] db_in,
    output logic [7:0] db_out,
    input  logic       brk_push,
    output logic [7:0] psr_to_id,
    input  logic [2:0] cond_sel,
    output logic       branch_taken
);
    import psr_pkg::*;

    psr_state_t state_q;
    logic [7:0] psr_q, psr_d;
    logic       ack_q;
    logic       plp;
    logic       capture;

    // A PLP in the same cycle defers the capture so the pulled byte is not
    // partially overwritten; the request is still high next cycle.
    always_comb begin
        plp     = flag_op_valid && flag_op == OP_PLP;
        capture = state_q == ST_IDLE && psr_update_request && !plp;
        psr_d   = psr_q;
        if (capture) begin
            psr_d[N_BIT] = n_result;
            psr_d[V_BIT] = v_result;
            psr_d[Z_BIT] = z_result;
            psr_d[C_BIT] = c_result;
        end
        // Applied after the capture so a flag op wins on its own bit.
        if (flag_op_valid) begin
            case (flag_op)
                OP_CLC:  psr_d[C_BIT] = 1'b0;
                OP_SEC:  psr_d[C_BIT] = 1'b1;
                OP_CLI:  psr_d[I_BIT] = 1'b0;
                OP_SEI:  psr_d[I_BIT] = 1'b1;
                OP_CLD:  psr_d[D_BIT] = 1'b0;
                OP_SED:  psr_d[D_BIT] = 1'b1;
                OP_CLV:  psr_d[V_BIT] = 1'b0;
                OP_PLP:  psr_d = (db_in & ~PSR_FIXED) | (psr_q & PSR_FIXED);
                OP_INT:  begin
                    psr_d[I_BIT] = 1'b1;
                    psr_d[D_BIT] = 1'b0;
                end
                default: psr_d = psr_d;
            endcase
        end
    end

    always_ff @(posedge mem_clk or negedge resb) begin
        if (!resb) begin
            state_q <= ST_IDLE;
            ack_q   <= 1'b0;
            psr_q   <= RESET_PSR | PSR_FIXED;
        end else begin
            psr_q <= psr_d;
            case (state_q)
                ST_IDLE: begin
                    ack_q   <= capture;
                    state_q <= capture ? ST_ACK : ST_IDLE;
                end
                ST_ACK: begin
                    ack_q   <= 1'b0;
                    state_q <= ST_WAIT_LOW;
                end
                ST_WAIT_LOW: begin
                    ack_q   <= 1'b0;
                    state_q <= psr_update_request ? ST_WAIT_LOW : ST_IDLE;
                end
                default: begin
                    ack_q   <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign ack_update_request = ack_q;
    assign psr_to_id          = psr_q;
    assign db_out             = {psr_q[N_BIT], psr_q[V_BIT], 1'b1, brk_push, psr_q[D_BIT:C_BIT]};

    branch_cond u_branch_cond (
        .n_i        (psr_q[N_BIT]),
        .v_i        (psr_q[V_BIT]),
        .z_i        (psr_q[Z_BIT]),
        .c_i        (psr_q[C_BIT]),
        .cond_sel_i (cond_sel_t'(cond_sel)),
        .taken_o    (branch_taken)
    );
endmodule
